shift_seq: RTL

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq.sv | 100 ++++++++++
 1 files changed

// File: rtl/shift_seq.sv
// Frame sequencer for a 4-bit shift register: parallel load, then LSB-first serialisation.
// Define SHIFT_SEQ_PARITY_EN to append an even-parity bit after the data bits.
//
// state   | meaning
// S_IDLE  | waiting for START
// S_LOAD  | register parallel-loads the held word
// S_SHIFT | four serial shifts, IS fills from the top
// S_PAR   | parity bit on SOUT (parity build only)
// S_DONE  | end-of-frame pulse, may accept the next frame directly
module shift_seq (
    input  logic       C,
    input  logic       CLR,
    input  logic       START,
    input  logic [3:0] DIN,
    input  logic       IS,
    output logic       SP,
    output logic       CE,
    output logic [3:0] Q,
    output logic       SOUT,
    output logic       BUSY,
    output logic       DONE
);

`ifdef SHIFT_SEQ_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_PAR, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;
`endif

    state_t     state;
    state_t     nxt;
    logic [3:0] hold;
    logic [2:0] cnt;

    function automatic state_t next_state(input state_t s, input logic start, input logic [2:0] n);
        next_state = S_IDLE;
        case (s)
            S_IDLE:  next_state = start ? S_LOAD : S_IDLE;
            S_LOAD:  next_state = S_SHIFT;
`ifdef SHIFT_SEQ_PARITY_EN
            S_SHIFT: next_state = (n == 3'd3) ? S_PAR : S_SHIFT;
            S_PAR:   next_state = S_DONE;
`else
            S_SHIFT: next_state = (n == 3'd3) ? S_DONE : S_SHIFT;
`endif
            S_DONE:  next_state = start ? S_LOAD : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    endfunction

    assign nxt = next_state(state, START, cnt);

`ifdef SHIFT_SEQ_PARITY_EN
    logic par_sel;
    assign SOUT = par_sel ? ^hold : Q[0];
`else
    assign SOUT = Q[0];
`endif

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(negedge C) begin
        if (CLR) begin
            state <= S_IDLE;
            hold  <= 4'b0000;
            cnt   <= 3'd0;
            Q     <= 4'b0000;
            SP    <= 1'b1;
            CE    <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
            par_sel <= 1'b0;
`endif
        end else begin
            state <= nxt;
            SP    <= (nxt != S_LOAD);
            CE    <= (nxt == S_LOAD) || (nxt == S_SHIFT);
            BUSY  <= (nxt != S_IDLE) && (nxt != S_DONE);
            DONE  <= (nxt == S_DONE);
`ifdef SHIFT_SEQ_PARITY_EN
            par_sel <= (nxt == S_PAR);
`endif
            case (state)
                S_IDLE, S_DONE: begin
                    if (START) hold <= DIN;
                end
                S_LOAD: begin
                    Q   <= hold;
                    cnt <= 3'd0;
                end
                S_SHIFT: begin
                    Q   <= {IS, Q[3:1]};
                    cnt <= cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
